// File: rtl/adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
// Holds the FSM state type, sizing functions and the full-adder cell.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int cnt_width(input int width, input int digit);
    int n;
    n = width / digit;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(
    input logic x,
    input logic y,
    input logic ci
  );
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/ripple_slice.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells.
// c_msb is the carry into the top bit, for signed overflow detection.
module ripple_slice
  import adder_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign {c[i+1], s[i]} = full_add(a[i], b[i], c[i]);
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: DIGIT bits per clock, LS digit first,
// registered carry, start/ready/valid handshake.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = num_digits(WIDTH, DIGIT);
  localparam int CW = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("serial_adder: WIDTH must be a multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0]       s_dig;
  logic                   c_dig;
  logic                   c_msb;
  logic [WIDTH+DIGIT-1:0] sum_ext;

  ripple_slice #(
    .DIGIT(DIGIT)
  ) u_slice (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .cin  (carry_q),
    .s    (s_dig),
    .cout (c_dig),
    .c_msb(c_msb)
  );

  // New digit enters at the top; after N shifts it sits LS-first.
  assign sum_ext = {s_dig, sum_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = c_dig;
        sum_d   = sum_ext[WIDTH+DIGIT-1:DIGIT];
        if (cnt_q == LAST) begin
          cout_d  = c_dig;
          ovf_d   = c_dig ^ c_msb;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign valid    = (state_q == DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: N=4 and N=1 instances against
// a plain-arithmetic reference model with random operands.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, start16;
  logic [15:0] a, b;
  logic        cin;

  logic        rdy4, vld4, co4, ov4;
  logic [15:0] s4;
  logic        rdy16, vld16, co16, ov16;
  logic [15:0] s16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(16), .DIGIT(4)) u_n4 (
    .clk(clk), .rst(rst), .start(start4),
    .a(a), .b(b), .cin(cin),
    .ready(rdy4), .valid(vld4), .sum(s4),
    .cout(co4), .overflow(ov4)
  );

  serial_adder #(.WIDTH(16), .DIGIT(16)) u_n1 (
    .clk(clk), .rst(rst), .start(start16),
    .a(a), .b(b), .cin(cin),
    .ready(rdy16), .valid(vld16), .sum(s16),
    .cout(co16), .overflow(ov16)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel_rdy(input bit w);
    return w ? rdy16 : rdy4;
  endfunction

  function automatic logic sel_vld(input bit w);
    return w ? vld16 : vld4;
  endfunction

  // One operation; optionally pokes start with junk during RUN.
  task automatic do_op(input bit w, input logic [15:0] ta,
                       input logic [15:0] tb, input logic tc,
                       input bit poke, input string tag);
    logic [16:0] full;
    logic        eov;
    int          n;
    int          lat;
    n    = w ? 1 : 4;
    full = {1'b0, ta} + {1'b0, tb} + {16'd0, tc};
    eov  = (ta[15] == tb[15]) && (full[15] != ta[15]);
    check({tag, "_rdy_before"}, sel_rdy(w), 1'b1);
    a = ta; b = tb; cin = tc;
    if (w) start16 = 1'b1; else start4 = 1'b1;
    tick();
    start4 = 1'b0; start16 = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    check({tag, "_rdy_run"}, sel_rdy(w), 1'b0);
    lat = 1;
    while (!sel_vld(w) && lat < 20) begin
      if (poke && lat == 2) begin
        a = 16'hFFFF;
        if (w) start16 = 1'b1; else start4 = 1'b1;
      end
      tick();
      start4 = 1'b0; start16 = 1'b0;
      lat++;
    end
    check({tag, "_latency"}, lat, n + 1);
    check({tag, "_sum"}, w ? s16 : s4, full[15:0]);
    check({tag, "_cout"}, w ? co16 : co4, full[16]);
    check({tag, "_ovf"}, w ? ov16 : ov4, eov);
    tick();
    check({tag, "_vld_pulse"}, sel_vld(w), 1'b0);
    check({tag, "_rdy_after"}, sel_rdy(w), 1'b1);
    check({tag, "_sum_hold"}, w ? s16 : s4, full[15:0]);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy4"}, rdy4, 1'b1);
    check({tag, "_vld4"}, vld4, 1'b0);
    check({tag, "_sum4"}, s4, 16'h0000);
    check({tag, "_co4"}, co4, 1'b0);
    check({tag, "_ov4"}, ov4, 1'b0);
    check({tag, "_rdy16"}, rdy16, 1'b1);
    check({tag, "_sum16"}, s16, 16'h0000);
  endtask

  initial begin
    int acc[$];
    int seen_vld;
    rst = 1'b1; start4 = 1'b0; start16 = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_reset_vals("in_reset");
      tick();
    end
    rst = 1'b0;
    tick();
    check_reset_vals("post_reset");

    do_op(0, 16'h00FF, 16'h0001, 1'b0, 0, "basic");
    do_op(0, 16'hFFFF, 16'h0000, 1'b1, 0, "wrap_cin");
    do_op(0, 16'h7FFF, 16'h0001, 1'b0, 0, "pos_ovf");
    do_op(0, 16'h8000, 16'h8000, 1'b0, 0, "neg_ovf");
    do_op(0, 16'h1234, 16'h1111, 1'b0, 1, "ignore_start");

    // Held start: accepts spaced N+2 = 6 edges apart.
    a = 16'h0101; b = 16'h0202; cin = 1'b0;
    start4 = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (rdy4) acc.push_back(i);
      tick();
    end
    start4 = 1'b0;
    check("held_count", acc.size(), 3);
    for (int i = 0; i < acc.size() && i < 3; i++)
      check("held_pos", acc[i], i * 6);
    for (int i = 0; i < 8 && !rdy4; i++) tick();
    check("held_sum", s4, 16'h0303);

    // Reset two cycles into RUN.
    a = 16'h5555; b = 16'h3333; cin = 1'b1;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_rdy", rdy4, 1'b1);
    check("midrst_vld", vld4, 1'b0);
    check("midrst_sum", s4, 16'h0000);
    check("midrst_co", co4, 1'b0);
    tick();
    rst = 1'b0;
    seen_vld = 0;
    for (int i = 0; i < 8; i++) begin
      if (vld4) seen_vld++;
      tick();
    end
    check("midrst_no_vld", seen_vld, 0);
    do_op(0, 16'h0003, 16'h0004, 1'b0, 0, "after_rst");

    do_op(1, 16'hFFFE, 16'h0001, 1'b1, 0, "n1_edge");
    do_op(1, 16'h7FFF, 16'h7FFF, 1'b1, 0, "n1_ovf");

    for (int i = 0; i < 24; i++) begin
      do_op(i[0], 16'($urandom), 16'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0), "rand");
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
